// File: rtl/alu_fpga_ctrl_if.sv
// rtl/alu_fpga_ctrl_if.sv - operand/opcode/result bus between the board controller and the ALU
interface alu_fpga_ctrl_if;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [3:0]  aluop;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_ovf;

    modport master (
        output port_a, port_b, aluop,
        input  alu_out, alu_zero, alu_neg, alu_ovf
    );

    modport slave (
        input  port_a, port_b, aluop,
        output alu_out, alu_zero, alu_neg, alu_ovf
    );
endinterface

// File: rtl/alu_fpga_ctrl.sv
// rtl/alu_fpga_ctrl.sv - switch/key ALU test harness with debounced keys, FSM and hex display (ALU_FPGA_BLANK_EN: leading-zero blanking)
module alu_fpga_ctrl #(
    parameter int SW_W            = 17,
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SIGN_EXT        = 0
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [SW_W:0]           sw,
    input  logic [3:0]              key_n,
    alu_fpga_ctrl_if.master         alu,
    output logic [7*NUM_DIGITS-1:0] hex_n,
    output logic [7:0]              ledr
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW} state_t;
    typedef enum logic [1:0] {PG_RESULT, PG_OPA, PG_OPB} page_t;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       level;
    logic [3:0]       press;
    logic [CNT_W-1:0] cnt [4];

    // Accepted levels reset to "pressed" so a key held through reset must be
    // released and pressed again before it produces a pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i]   <= '0;
                    level[i] <= sync2[i];
                    press[i] <= level[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic [31:0] ext;
    logic [3:0]  sw_op;
    logic        unused_sw;

    assign unused_sw = ^sw;

    generate
        if (SIGN_EXT != 0) begin : g_sext
            assign ext = {{(32-SW_W){sw[SW_W-1]}}, sw[SW_W-1:0]};
        end else begin : g_zext
            assign ext = {{(32-SW_W){1'b0}}, sw[SW_W-1:0]};
        end
        if (SW_W >= 3) begin : g_op_direct
            assign sw_op = sw[3:0];
        end else begin : g_op_pad
            assign sw_op = 4'(sw);
        end
    endgenerate

    state_t      state;
    page_t       page;
    logic [31:0] result;
    logic [2:0]  flags;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= LOAD_A;
            page       <= PG_RESULT;
            alu.port_a <= '0;
            alu.port_b <= '0;
            alu.aluop  <= '0;
            result     <= '0;
            flags      <= '0;
        end else begin
            if (press[2]) begin
                case (page)
                    PG_RESULT: page <= PG_OPA;
                    PG_OPA:    page <= PG_OPB;
                    default:   page <= PG_RESULT;
                endcase
            end
            if (press[1]) begin
                state      <= LOAD_A;
                alu.port_a <= '0;
                alu.port_b <= '0;
                alu.aluop  <= '0;
                result     <= '0;
                flags      <= '0;
            end else begin
                case (state)
                    LOAD_A: if (press[0]) begin
                        alu.port_a <= ext;
                        state      <= LOAD_B;
                    end
                    LOAD_B: if (press[0]) begin
                        alu.port_b <= ext;
                        state      <= LOAD_OP;
                    end
                    LOAD_OP: if (press[0]) begin
                        alu.aluop <= sw_op;
                        state     <= EXEC;
                    end
                    EXEC: begin
                        result <= alu.alu_out;
                        flags  <= {alu.alu_neg, alu.alu_ovf, alu.alu_zero};
                        state  <= SHOW;
                    end
                    SHOW: begin
                        if (press[0])      state <= LOAD_A;
                        else if (press[3]) state <= EXEC;
                    end
                    default: state <= LOAD_A;
                endcase
            end
        end
    end

    logic [2:0] state_led;

    always_comb begin
        state_led = 3'b000;
        case (state)
            LOAD_A:  state_led = 3'b001;
            LOAD_B:  state_led = 3'b010;
            LOAD_OP: state_led = 3'b100;
            default: state_led = 3'b000;
        endcase
    end

    assign ledr = {page, state_led, flags};

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h27;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    logic [31:0]             word;
    logic [7*NUM_DIGITS-1:0] hex_next;
`ifdef ALU_FPGA_BLANK_EN
    logic [2:0]              top_nib;
`endif

    always_comb begin
        case (page)
            PG_OPA:  word = alu.port_a;
            PG_OPB:  word = alu.port_b;
            default: word = result;
        endcase
    end

    always_comb begin
        hex_next = '0;
`ifdef ALU_FPGA_BLANK_EN
        // Highest nonzero nibble wins; a zero word leaves only digit 0 lit.
        top_nib = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (word[4*i +: 4] != 4'h0) top_nib = 3'(i);
        end
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_next[7*i +: 7] = seg7(word[4*i +: 4]);
`ifdef ALU_FPGA_BLANK_EN
            if (3'(i) > top_nib) hex_next[7*i +: 7] = 7'h7F;
`endif
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) hex_n <= {NUM_DIGITS{7'h40}};
        else       hex_n <= hex_next;
    end
endmodule
